// File: rtl/logic_pkg.sv
// logic_pkg: shared definitions for the pipelined bitwise logic unit.
//   LOGIC_OP_W     : width of the operation select field.
//   OP_AND..OP_PASS: operation select encodings.
package logic_pkg;

  localparam int LOGIC_OP_W = 3;

  localparam logic [LOGIC_OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [LOGIC_OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [LOGIC_OP_W-1:0] OP_XOR  = 3'd2;
  localparam logic [LOGIC_OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [LOGIC_OP_W-1:0] OP_NOR  = 3'd4;
  localparam logic [LOGIC_OP_W-1:0] OP_XNOR = 3'd5;
  localparam logic [LOGIC_OP_W-1:0] OP_NOT  = 3'd6;
  localparam logic [LOGIC_OP_W-1:0] OP_PASS = 3'd7;

endpackage

// File: rtl/logic_unit_pipe_elastic_slot.sv
// elastic_slot: one-entry valid/ready register slice.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data payload
// The slot loads when empty or when its current entry leaves in the same
// cycle, so a chain of slots sustains one beat per cycle. CLR_DATA selects
// whether the payload register is cleared by reset (needed only where the
// payload is directly visible at the block boundary).
module elastic_slot #(
  parameter int DATA_W   = 8,
  parameter bit CLR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              vld_q;
  logic [DATA_W-1:0] data_q;
  logic              load;

  assign in_ready = ~vld_q | out_ready;
  assign load     = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
    end else if (in_ready) begin
      vld_q <= in_valid;
    end
  end

  generate
    if (CLR_DATA) begin : g_clr
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_q <= '0;
        end else if (load) begin
          data_q <= in_data;
        end
      end
    end else begin : g_hold
      always_ff @(posedge clk) begin
        if (load) begin
          data_q <= in_data;
        end
      end
    end
  endgenerate

  assign out_valid = vld_q;
  assign out_data  = data_q;

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage elastic bitwise logic unit.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand beat handshake; op, in0, in1 sampled on accept
//   out_valid/out_ready : result beat handshake
//   out                 : WIDTH-bit result f(op, in0, in1)
//   zero/all_ones/parity: reductions of out (NOR, AND, XOR)
// Stage 1 registers the bitwise result, stage 2 registers the result together
// with its flags. All outputs except in_ready come straight from registers.
module logic_unit_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LOGIC_OP_W-1:0] op,
  input  logic [WIDTH-1:0]      in0,
  input  logic [WIDTH-1:0]      in1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out,
  output logic                  zero,
  output logic                  all_ones,
  output logic                  parity
);

  function automatic logic [WIDTH-1:0] logic_op(input logic [LOGIC_OP_W-1:0] sel,
                                                input logic [WIDTH-1:0]      a,
                                                input logic [WIDTH-1:0]      b);
    logic [WIDTH-1:0] r;
    case (sel)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_NOT:  r = ~a;
      default: r = a;  // OP_PASS
    endcase
    return r;
  endfunction

  // Holds in_ready low during reset and until the first edge after release.
  logic live;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live <= 1'b0;
    end else begin
      live <= 1'b1;
    end
  end

  logic [WIDTH-1:0] res_p0;
  logic [WIDTH-1:0] res_p1;
  logic             vld_p1;
  logic             s1_ready;
  logic             s2_ready;
  logic [WIDTH+2:0] pkt_p1;
  logic [WIDTH+2:0] pkt_p2;

  // ---- stage 0 -> 1: operation decode ----
  assign res_p0   = logic_op(op, in0, in1);
  assign in_ready = live & s1_ready;

  elastic_slot #(
    .DATA_W  (WIDTH),
    .CLR_DATA(1'b0)
  ) u_s1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid & live),
    .in_ready (s1_ready),
    .in_data  (res_p0),
    .out_valid(vld_p1),
    .out_ready(s2_ready),
    .out_data (res_p1)
  );

  // ---- stage 1 -> 2: flag reduction, packed above the result ----
  assign pkt_p1 = {~|res_p1, &res_p1, ^res_p1, res_p1};

  elastic_slot #(
    .DATA_W  (WIDTH + 3),
    .CLR_DATA(1'b1)
  ) u_s2 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (vld_p1),
    .in_ready (s2_ready),
    .in_data  (pkt_p1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (pkt_p2)
  );

  // ---- stage 2: registered outputs ----
  assign {zero, all_ones, parity, out} = pkt_p2;

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit; successor to the fixed 16-bit per-gate arrays in the ch1 gate library.
- Applies one of eight selectable bitwise operations to two WIDTH-bit operands.
- Produces WIDTH-bit result plus reduction flags (zero, all-ones, parity).
- Two elastic pipeline stages with valid/ready handshake; sits between an operand source and the ALU/register-file datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit can accept operand beat this cycle.
- op  input  3  operation select, sampled with operands.
- in0  input  WIDTH  operand A.
- in1  input  WIDTH  operand B.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result this cycle.
- out  output  WIDTH  result.
- zero  output  1  result is all zeros.
- all_ones  output  1  result is all ones.
- parity  output  1  XOR-reduction of result.

Behaviour:
- Reset: clk and rst only; reset is asynchronous and active-high. While rst is high, all valid bits, out, zero, all_ones and parity are 0. in_ready is 1 from the first clock edge after rst deasserts.
- op encoding:
  - 0 AND
  - 1 OR
  - 2 XOR
  - 3 NAND
  - 4 NOR
  - 5 XNOR
  - 6 NOT in0 (in1 ignored)
  - 7 PASS in0
- Stage 1 (S1): on accept (in_valid & in_ready), registers the bitwise result f(op, in0, in1) and sets s1_valid.
- Stage 2 (S2): on S1->S2 transfer, registers the S1 result and computes the flags from it: zero = ~|r, all_ones = &r, parity = ^r.
  - out, zero, all_ones and parity are S2 register outputs; they never depend combinationally on inputs.
- Handshake:
  - A beat transfers when valid & ready are both high at a clock edge.
  - Once out_valid is high, out and flags are held stable until out_ready is sampled high.
  - in_valid may drop without a transfer; the unit takes no action.
- Per-stage advance rule: a stage may load when it is empty, or when its current content leaves in the same cycle.
  - in_ready = ~s1_valid | s2_can_load.
  - s2_can_load = ~s2_valid | out_ready.
- Latency: exactly 2 cycles from accept to out_valid when there is no stall. Throughput is 1 beat/cycle while out_ready is held high.
- Full: both stages occupied and out_ready low -> in_ready low; no beat is dropped or overwritten.
- Empty: out_valid low; out and flags keep their last values (don't-care to consumers).
- Simultaneous accept, S1->S2 transfer and output pop in one cycle: all three occur; order is preserved.
- in_ready may depend combinationally on out_ready. No other combinational input->output path is permitted.
- Reset mid-operation: in-flight beats are discarded; outputs return to reset values immediately (asynchronous).
- WIDTH=1: flags degenerate to zero = ~r, all_ones = r, parity = r.

Decomposition:
- Shared package logic_pkg:
  - op encoding constants OP_AND..OP_PASS.
  - LOGIC_OP_W = 3.
- Sub-module elastic_slot: a one-entry valid/ready register slice, parametrised on data width.
  - Instantiated twice: S1 carries WIDTH bits; S2 carries WIDTH+3 bits (result + flags).
- Op decode and flag reduction stay inline in logic_unit_pipe.

Test Plan:
- Reset, then out_ready=1; send in0=16'hF0F0, in1=16'hFF00 with op=0,1,2,3 back-to-back -> out = 16'hF000, 16'hFFF0, 16'h0FF0, 16'h0FFF on four consecutive cycles, first one 2 cycles after accept.
- op=6, in0=16'hFFFF -> out=0, zero=1, all_ones=0, parity=0. Then op=7, in0=16'hFFFF -> all_ones=1, parity=0. Then op=7, in0=16'h0001 -> parity=1.
- Backpressure: out_ready=0, issue 3 beats -> first two accepted, in_ready low on the third. Raise out_ready -> results emerge in issue order with no loss or duplication, and out is stable during the stall.
- Randomised in_valid/out_ready toggling over 1000 beats against a scoreboard -> every result matches the reference function, in order, with no drops.
- Assert rst while both stages are full -> out_valid=0 asynchronously and no stale beat appears after release. in_ready=1 one cycle after release.
- WIDTH=1 and WIDTH=64 builds: op=4 with in0=in1=0 -> out all ones, all_ones=1; parity=1 for WIDTH=1, parity=0 for WIDTH=64.
